// File: rtl/cla_wide_add_seq_pkg.sv
// Shared definitions for the wide sequential CLA adder.
// Contents:
//   SLICE_W          width of one adder slice
//   state_e          sequencer states (IDLE=0, ADD=1, DONE=2)
//   cla4_gen         group generate of a 4-bit lookahead block
//   cla4_carry_in    carries into each bit of a 4-bit lookahead block
package cla_wide_add_seq_pkg;

  localparam int unsigned SLICE_W = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAdd  = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic logic cla4_gen(input logic [3:0] g, input logic [3:0] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  // Bit 0 of the result is the block carry-in itself.
  function automatic logic [3:0] cla4_carry_in(input logic [3:0] g, input logic [3:0] p,
                                               input logic ci);
    logic [3:0] c;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    return c;
  endfunction

endpackage

// File: rtl/cla_16bit.sv
// 16-bit two-level carry-lookahead adder (four 4-bit blocks plus a group lookahead).
// Ports:
//   a, b   16-bit operands
//   cin    carry-in
//   s      16-bit sum
//   cout   carry-out of bit 15
module cla_16bit
  import cla_wide_add_seq_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  grp_g;
  logic [3:0]  grp_p;
  logic [3:0]  grp_c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    grp_g = '0;
    grp_p = '0;
    c     = '0;
    for (int i = 0; i < 4; i++) begin
      grp_g[i] = cla4_gen(g[4*i +: 4], p[4*i +: 4]);
      grp_p[i] = &p[4*i +: 4];
    end
    grp_c = cla4_carry_in(grp_g, grp_p, cin);
    for (int i = 0; i < 4; i++) begin
      c[4*i +: 4] = cla4_carry_in(g[4*i +: 4], p[4*i +: 4], grp_c[i]);
    end
  end

  assign s    = p ^ c;
  assign cout = cla4_gen(grp_g, grp_p) | (&grp_p & cin);

endmodule

// File: rtl/cla_wide_add_seq.sv
// Sequencer performing one WORDS*16-bit addition through a single cla_16bit,
// one slice per clock, least-significant slice first, carry chained in a register.
// Ports:
//   CLK       clock, rising edge
//   reset     asynchronous active-low reset
//   start     request, accepted in IDLE or DONE
//   a, b, cin wide operands and carry-in, latched on accepted start
//   busy      high while slices are being added
//   done      one-cycle pulse when sum/cout/overflow are final
//   sum       wide result (fills in progressively during ADD)
//   cout      carry out of the most significant slice
//   overflow  two's-complement overflow of the wide add
module cla_wide_add_seq
  import cla_wide_add_seq_pkg::*;
#(
  parameter int unsigned WORDS = 4
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     start,
  input  logic [SLICE_W*WORDS-1:0] a,
  input  logic [SLICE_W*WORDS-1:0] b,
  input  logic                     cin,
  output logic                     busy,
  output logic                     done,
  output logic [SLICE_W*WORDS-1:0] sum,
  output logic                     cout,
  output logic                     overflow
);

  localparam int unsigned W    = SLICE_W * WORDS;
  localparam int unsigned IdxW = $clog2(WORDS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic [IdxW-1:0] idx_q, idx_d;

  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_s;
  logic               slice_cout;

  assign slice_a = a_q[idx_q*SLICE_W +: SLICE_W];
  assign slice_b = b_q[idx_q*SLICE_W +: SLICE_W];

  cla_16bit u_cla (
    .a   (slice_a),
    .b   (slice_b),
    .cin (carry_q),
    .s   (slice_s),
    .cout(slice_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = StAdd;
        end else begin
          state_d = StIdle;
        end
      end
      StAdd: begin
        sum_d[idx_q*SLICE_W +: SLICE_W] = slice_s;
        carry_d = slice_cout;
        if (idx_q == LastIdx) begin
          cout_d  = slice_cout;
          // Operands share a sign but the top sum bit differs from it.
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (slice_s[SLICE_W-1] != a_q[W-1]);
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end

  assign busy     = (state_q == StAdd);
  assign done     = (state_q == StDone);
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_cla_wide_add_seq.sv
// Self-checking bench for cla_wide_add_seq with WORDS=4 (64-bit operands).
module tb_cla_wide_add_seq;

  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = 16 * WORDS;
  localparam int          BOUND = 20;

  logic         CLK = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  cla_wide_add_seq #(.WORDS(WORDS)) dut (
    .CLK     (CLK),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .cin     (cin),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .cout    (cout),
    .overflow(overflow)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: exact wide arithmetic, overflow from operand and result signs.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc,
                       output logic [W-1:0] ms, output logic mco, output logic mov);
    logic [W:0] full;
    full = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
    ms   = full[W-1:0];
    mco  = full[W];
    mov  = (ma[W-1] == mb[W-1]) && (ms[W-1] != ma[W-1]);
  endtask

  // Called at a negedge; returns at the negedge where done is high (or bound expires).
  task automatic wait_done(input string tag, output int lat);
    lat = 0;
    while (!done && lat < BOUND) begin
      @(negedge CLK);
      lat++;
    end
    check($sformatf("%s done seen", tag), done, 1);
  endtask

  // One isolated operation starting from IDLE at a negedge.
  task automatic run_op(input string tag, input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                        input logic op_c, input logic [W-1:0] es, input logic eco,
                        input logic eov);
    int lat;
    a = op_a; b = op_b; cin = op_c; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    // Scramble inputs: the latched copies must be used.
    a = ~op_a; b = ~op_b; cin = ~op_c;
    check($sformatf("%s busy", tag), busy, 1);
    @(negedge CLK);
    lat = 1;
    while (!done && lat < BOUND) begin
      @(negedge CLK);
      lat++;
    end
    check($sformatf("%s latency", tag), lat, WORDS);
    check($sformatf("%s sum", tag), sum, es);
    check($sformatf("%s cout", tag), cout, eco);
    check($sformatf("%s overflow", tag), overflow, eov);
    @(negedge CLK);
    check($sformatf("%s done pulse width", tag), done, 0);
    check($sformatf("%s sum hold", tag), sum, es);
  endtask

  initial begin
    logic [W-1:0] rs;
    logic         rco, rov;
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [W-1:0] bb_a[3];
    logic [W-1:0] bb_b[3];
    logic         bb_c[3];
    int           lat;
    int           last_cyc;
    bit           saw_done;

    vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0};
    vecs[1] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[2] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0};
    vecs[4] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
                64'h2222_2222_2222_2211, 1'b0, 1'b0};
    vecs[5] = '{64'h0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0};

    reset = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset sum", sum, 0);
    check("reset cout", cout, 0);
    check("reset overflow", overflow, 0);
    repeat (2) @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].c,
             vecs[i].s, vecs[i].co, vecs[i].ov);
    end

    // Start pulses during ADD must not disturb the operation in flight.
    a = 64'h0000_0001_0000_FFFF; b = 64'h1; cin = 1'b0; start = 1'b1;
    @(negedge CLK);
    for (int k = 0; k < 3; k++) begin
      a = {$urandom, $urandom}; b = 64'hFFFF_FFFF_FFFF_FFFF; cin = 1'b1; start = 1'b1;
      @(negedge CLK);
    end
    start = 1'b0;
    wait_done("busy-ignore", lat);
    check("busy-ignore sum", sum, 64'h0000_0001_0001_0000);
    check("busy-ignore cout", cout, 0);
    check("busy-ignore overflow", overflow, 0);
    @(negedge CLK);

    // Reset in the second ADD cycle: everything clears, no done.
    a = 64'h1111_2222_3333_4444; b = 64'h1; cin = 1'b0; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    @(negedge CLK);
    reset = 1'b0;
    #1;
    check("midreset busy", busy, 0);
    check("midreset done", done, 0);
    check("midreset sum", sum, 0);
    check("midreset cout", cout, 0);
    check("midreset overflow", overflow, 0);
    saw_done = 1'b0;
    @(negedge CLK);
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      if (done) saw_done = 1'b1;
    end
    check("midreset no done", saw_done, 0);
    model(64'h1111_2222_3333_4444, 64'h1, 1'b0, rs, rco, rov);
    run_op("post-reset", 64'h1111_2222_3333_4444, 64'h1, 1'b0, rs, rco, rov);

    // Back-to-back: start held high, next operands presented in each DONE cycle.
    bb_a[0] = 64'hFFFF_0000_FFFF_0000; bb_b[0] = 64'h0001_FFFF_0001_FFFF; bb_c[0] = 1'b1;
    bb_a[1] = 64'h7FFF_0000_0000_0000; bb_b[1] = 64'h7FFF_0000_0000_0000; bb_c[1] = 1'b0;
    bb_a[2] = 64'hDEAD_BEEF_CAFE_F00D; bb_b[2] = 64'h0123_4567_89AB_CDEF; bb_c[2] = 1'b1;
    a = bb_a[0]; b = bb_b[0]; cin = bb_c[0]; start = 1'b1;
    last_cyc = 0;
    @(negedge CLK);
    for (int k = 0; k < 3; k++) begin
      wait_done($sformatf("b2b%0d", k), lat);
      model(bb_a[k], bb_b[k], bb_c[k], rs, rco, rov);
      check($sformatf("b2b%0d sum", k), sum, rs);
      check($sformatf("b2b%0d cout", k), cout, rco);
      check($sformatf("b2b%0d overflow", k), overflow, rov);
      if (k > 0) check($sformatf("b2b%0d period", k), cyc - last_cyc, WORDS + 1);
      last_cyc = cyc;
      if (k < 2) begin
        a = bb_a[k+1]; b = bb_b[k+1]; cin = bb_c[k+1];
      end else begin
        start = 1'b0;
      end
      @(negedge CLK);
      if (k < 2) check($sformatf("b2b%0d reaccepted", k), busy, 1);
    end
    check("b2b idle after", busy | done, 0);

    // Randomized operations against the arithmetic model.
    for (int n = 0; n < 20; n++) begin
      ra = {$urandom, $urandom};
      rb = (n % 4 == 0) ? ~ra : {$urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      model(ra, rb, rc, rs, rco, rov);
      run_op($sformatf("rand%0d", n), ra, rb, rc, rs, rco, rov);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cla_wide_add_seq.md
Name: cla_wide_add_seq

Overview:
- Sequencer that feeds the existing 16-bit carry-lookahead adder (cla_16bit) to perform one wide addition of WORDS×16 bits.
- Sends one 16-bit slice per clock, least-significant slice first, and chains the carry through a register.
- Sits directly upstream of cla_16bit. It latches wide operands on a start pulse and returns the wide sum, carry-out and signed overflow with a done pulse.

Parameters:
- WORDS, 4, number of 16-bit slices (operand width = 16*WORDS); legal range 2..16

Ports:
- CLK  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- start  input  1  request; sampled only when the block is not busy
- a  input  16*WORDS  operand A, sampled on accepted start
- b  input  16*WORDS  operand B, sampled on accepted start
- cin  input  1  carry-in, sampled on accepted start
- busy  output  1  high while slices are being added
- done  output  1  one-cycle pulse: sum/cout/overflow valid
- sum  output  16*WORDS  wide result
- cout  output  1  carry out of the MSB slice
- overflow  output  1  two's-complement overflow of the wide add

Behaviour:
- Clock and reset: one clock, CLK. reset is asynchronous and active-low.
- Reset values:
  - state = IDLE
  - busy = 0, done = 0
  - sum = 0, cout = 0, overflow = 0
  - slice counter = 0, carry register = 0
  - operand registers = 0
- States: IDLE, ADD, DONE.
- IDLE:
  - start=1 → latch a, b, cin into registers; carry_reg ← cin; idx ← 0; go to ADD.
  - start=0 → stay in IDLE.
- ADD (busy=1):
  - Drive cla_16bit with a_reg[idx slice], b_reg[idx slice] and carry_reg.
  - On the clock edge: sum[idx slice] ← s; carry_reg ← cout of the instance.
  - If idx == WORDS-1:
    - register cout ← instance cout;
    - overflow ← (a_reg MSB == b_reg MSB) && (s[15] != a_reg MSB);
    - go to DONE.
  - Otherwise idx ← idx+1.
- DONE: done=1 for exactly one cycle; busy=0.
  - start=1 in DONE → accepted exactly as in IDLE (back-to-back operation, next state ADD).
  - start=0 → IDLE.
- Latency: start accepted at edge t → ADD occupies edges t+1..t+WORDS → done=1 during the cycle after edge t+WORDS. Throughput is one result per WORDS+1 cycles.
- start while busy=1: ignored. It has no effect on the operands or on the operation in flight.
- Operand changes after acceptance: no effect on the result, because operands are latched.
- sum holding:
  - sum, cout and overflow hold their last values from done until the next accepted start.
  - During ADD, sum slices update progressively, least-significant first.
  - cout and overflow update only on the final slice.
- Arithmetic: {cout,sum} = a + b + cin exactly, modulo 2^(16*WORDS+1). No saturation.
- Reset mid-operation: all state returns to the reset values immediately; done is not emitted; the in-flight operation is lost.
- Slice index: $clog2(WORDS) bits wide, with no wrap beyond WORDS-1.

Decomposition:
- Shared package:
  - SLICE_W = 16;
  - state encoding IDLE=2'd0, ADD=2'd1, DONE=2'd2.
- Sub-module: one instance of the existing cla_16bit (ports a, b, cin, s, cout). No other sub-modules.

Test Plan:
- Reset mid-operation: assert reset low in the 2nd ADD cycle → busy=0, done never pulses, sum=0, cout=0; next start completes normally.
- Carry ripples across all slices (WORDS=4): a=64'hFFFF_FFFF_FFFF_FFFF, b=0, cin=1 → done 5 cycles after start, sum=0, cout=1, overflow=0.
- Signed overflow: a=64'h7FFF_FFFF_FFFF_FFFF, b=1, cin=0 → sum=64'h8000_0000_0000_0000, cout=0, overflow=1.
- Start while busy is ignored: start pulses during ADD with different operands; a=64'h0000_0001_0000_FFFF, b=64'h1, cin=0 → result sum=64'h0000_0001_0001_0000, matching the first operands only.
- Back-to-back: start held high through DONE → second operation accepted in the DONE cycle, done pulses exactly every 5 cycles, each result correct.
- Randomized self-check: 20 random {a, b, cin} operations checked against the behavioural a+b+cin on the done cycle; the bench prints pass/fail and a success count.
